// File: rtl/intadd_ctrl.sv
// Round-robin front-end for the combinational intadd datapath.
// Build option: INTADD_CTRL_PREC_CHK_EN flags illegal precision as rsp_err.

module intadd (
  input  logic         inst_valid,
  input  logic [127:0] src0,
  input  logic [127:0] src1,
  input  logic [127:0] src2,
  input  logic [1:0]   prec_s0,
  input  logic [1:0]   prec_s1,
  input  logic [1:0]   prec_s2,
  input  logic         sign_s0,
  input  logic         sign_s1,
  input  logic         sign_s2,
  output logic [127:0] dst_reg0,
  output logic [127:0] dst_reg1
);

  function automatic logic [10:0] ext8(
    input logic [7:0] v,
    input logic       s
  );
    return {{3{s & v[7]}}, v};
  endfunction

  logic mode8;
  logic mode32;

  assign mode8  = (prec_s0 == 2'b00) && (prec_s1 == 2'b00)
               && (prec_s2 == 2'b00);
  assign mode32 = (prec_s0 == 2'b11) && (prec_s1 == 2'b11);

  // 8-bit mode: 16 lanes of src0+src1+src2 widened to 16 bits,
  // low bytes in dst_reg0, high bytes in dst_reg1.
  always_comb begin : add_c
    logic [10:0] sum;
    sum      = '0;
    dst_reg0 = '0;
    dst_reg1 = '0;
    if (inst_valid && mode8) begin
      for (int l = 0; l < 16; l++) begin
        sum = ext8(src0[8*l +: 8], sign_s0)
            + ext8(src1[8*l +: 8], sign_s1)
            + ext8(src2[8*l +: 8], sign_s2);
        dst_reg0[8*l +: 8] = sum[7:0];
        dst_reg1[8*l +: 8] = {{5{sum[10]}}, sum[10:8]};
      end
    end else if (inst_valid && mode32) begin
      for (int l = 0; l < 4; l++) begin
        dst_reg0[32*l +: 32] = src0[32*l +: 32]
                             + src1[32*l +: 32];
      end
    end
  end

endmodule

module intadd_ctrl #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_src0,
  input  logic [NREQ*128-1:0] req_src1,
  input  logic [NREQ*128-1:0] req_src2,
  input  logic [NREQ*6-1:0]   req_prec,
  input  logic [NREQ*3-1:0]   req_sign,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_dst0,
  output logic [127:0]        rsp_dst1,
  output logic                rsp_err,
  output logic                busy,
  output logic [15:0]         op_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [127:0]   s0;
    logic [127:0]   s1;
    logic [127:0]   s2;
    logic [5:0]     prec;
    logic [2:0]     sign;
    logic [IDW-1:0] id;
  } op_t;

  state_t          state;
  op_t             op_q;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            inst_valid;
  logic [127:0]    dst_reg0;
  logic [127:0]    dst_reg1;
  logic [15:0]     cnt_q;

  always_comb begin : arb_c
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end

  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
  assign rsp_id    = op_q.id;
  assign op_cnt    = cnt_q;

`ifdef INTADD_CTRL_PREC_CHK_EN
  logic legal;
  logic err_q;
  assign legal = (op_q.prec == 6'b00_00_00)
              || (op_q.prec[3:0] == 4'b11_11);
  assign inst_valid = (state == EXEC) && legal;
  assign rsp_err    = err_q;
`else
  assign inst_valid = (state == EXEC);
  assign rsp_err    = 1'b0;
`endif

  intadd u_intadd (
    .inst_valid (inst_valid),
    .src0       (op_q.s0),
    .src1       (op_q.s1),
    .src2       (op_q.s2),
    .prec_s0    (op_q.prec[1:0]),
    .prec_s1    (op_q.prec[3:2]),
    .prec_s2    (op_q.prec[5:4]),
    .sign_s0    (op_q.sign[0]),
    .sign_s1    (op_q.sign[1]),
    .sign_s2    (op_q.sign[2]),
    .dst_reg0   (dst_reg0),
    .dst_reg1   (dst_reg1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_dst0  <= '0;
      rsp_dst1  <= '0;
      busy      <= 1'b0;
      cnt_q     <= '0;
`ifdef INTADD_CTRL_PREC_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            op_q.s0   <= req_src0[gnt_idx*128 +: 128];
            op_q.s1   <= req_src1[gnt_idx*128 +: 128];
            op_q.s2   <= req_src2[gnt_idx*128 +: 128];
            op_q.prec <= req_prec[gnt_idx*6 +: 6];
            op_q.sign <= req_sign[gnt_idx*3 +: 3];
            op_q.id   <= gnt_idx;
            rr_ptr    <= gnt_idx;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_dst0  <= dst_reg0;
          rsp_dst1  <= dst_reg1;
          rsp_valid <= 1'b1;
`ifdef INTADD_CTRL_PREC_CHK_EN
          err_q     <= !legal;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cnt_q     <= cnt_q + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intadd_ctrl.sv
// Randomized self-checking bench for intadd_ctrl.
// Reference model computes lane sums with plain integer arithmetic.

module tb_intadd_ctrl;
  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_src0;
  logic [NREQ*128-1:0] req_src1;
  logic [NREQ*128-1:0] req_src2;
  logic [NREQ*6-1:0]   req_prec;
  logic [NREQ*3-1:0]   req_sign;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [127:0]        rsp_dst0;
  logic [127:0]        rsp_dst1;
  logic                rsp_err;
  logic                busy;
  logic [15:0]         op_cnt;

  logic [127:0] s0 [NREQ];
  logic [127:0] s1 [NREQ];
  logic [127:0] s2 [NREQ];
  logic [5:0]   pr [NREQ];
  logic [2:0]   sg [NREQ];

  int          n_chk  = 0;
  int          n_fail = 0;
  int          last   = NREQ - 1;
  logic [15:0] cnt    = '0;
  int          waited;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_src0[128*i +: 128] = s0[i];
      req_src1[128*i +: 128] = s1[i];
      req_src2[128*i +: 128] = s2[i];
      req_prec[6*i +: 6]     = pr[i];
      req_sign[3*i +: 3]     = sg[i];
    end
  end

  intadd_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src0  (req_src0),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_prec  (req_prec),
    .req_sign  (req_sign),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_dst0  (rsp_dst0),
    .rsp_dst1  (rsp_dst1),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bval(input logic [7:0] v, input logic s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  function automatic void ref_add(
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic [127:0] c,
    input  logic [5:0]   p,
    input  logic [2:0]   s,
    output logic [127:0] d0,
    output logic [127:0] d1,
    output logic         e
  );
    int     sum;
    longint w;
    d0 = '0;
    d1 = '0;
    e  = 1'b0;
    if (p == 6'd0) begin
      for (int l = 0; l < 16; l++) begin
        sum = bval(a[8*l +: 8], s[0]) + bval(b[8*l +: 8], s[1])
            + bval(c[8*l +: 8], s[2]);
        d0[8*l +: 8] = 8'(sum & 255);
        d1[8*l +: 8] = 8'((sum >>> 8) & 255);
      end
    end else if (p[1:0] == 2'b11 && p[3:2] == 2'b11) begin
      for (int l = 0; l < 4; l++) begin
        w = (longint'(a[32*l +: 32]) + longint'(b[32*l +: 32]))
          % 64'h1_0000_0000;
        d0[32*l +: 32] = 32'(w);
      end
    end else begin
`ifdef INTADD_CTRL_PREC_CHK_EN
      e = 1'b1;
`endif
    end
  endfunction

  function automatic int winner(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_req(input int i);
    s0[i] = {$urandom, $urandom, $urandom, $urandom};
    s1[i] = {$urandom, $urandom, $urandom, $urandom};
    s2[i] = {$urandom, $urandom, $urandom, $urandom};
    sg[i] = 3'($urandom);
    case ($urandom % 4)
      0:       pr[i] = 6'd0;
      1:       pr[i] = {2'($urandom), 4'hF};
      2:       pr[i] = 6'd0;
      default: pr[i] = 6'($urandom);
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last  = NREQ - 1;
    cnt   = '0;
  endtask

  // Called at a negedge with requester inputs already driven.
  task automatic do_op(
    input  int stall,
    input  bit keep,
    input  bit rst_mid,
    output int wt
  );
    int           g;
    logic [127:0] e0;
    logic [127:0] e1;
    logic         ee;
    rsp_ready = (stall == 0);
    #1;
    wt = 0;
    while (req_ready == '0 && wt < 20) begin
      @(negedge clk);
      #1;
      wt++;
    end
    if (req_ready == '0) begin
      chk("accept_timeout", 128'(req_ready), 128'(1));
      return;
    end
    g = winner(req_valid);
    chk("gnt", 128'(req_ready), 128'(1) << g);
    ref_add(s0[g], s1[g], s2[g], pr[g], sg[g], e0, e1, ee);
    last = g;
    @(negedge clk);
    chk("exec_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("exec_busy", 128'(busy), 128'(1));
    chk("exec_ready", 128'(req_ready), 128'(0));
    if (keep) rand_req(g);
    else req_valid[g] = 1'b0;
    @(negedge clk);
    chk("rsp_valid", 128'(rsp_valid), 128'(1));
    chk("rsp_id", 128'(rsp_id), 128'(g));
    chk("rsp_dst0", rsp_dst0, e0);
    chk("rsp_dst1", rsp_dst1, e1);
    chk("rsp_err", 128'(rsp_err), 128'(ee));
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_op_cnt", 128'(op_cnt), 128'(0));
      chk("rst_dst0", rsp_dst0, 128'(0));
      chk("rst_dst1", rsp_dst1, 128'(0));
      chk("rst_ready", 128'(req_ready), 128'(0));
      @(negedge clk);
      rst_n     = 1'b1;
      last      = NREQ - 1;
      cnt       = '0;
      rsp_ready = 1'b1;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 128'(rsp_valid), 128'(1));
      chk("stall_dst0", rsp_dst0, e0);
      chk("stall_id", 128'(rsp_id), 128'(g));
      chk("stall_ready", 128'(req_ready), 128'(0));
      chk("stall_busy", 128'(busy), 128'(1));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cnt++;
    chk("op_cnt", 128'(op_cnt), 128'(cnt));
    chk("done_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("done_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) rand_req(i);
    @(negedge clk);
    #1;
    chk("reset_ready", 128'(req_ready), 128'(0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_op_cnt", 128'(op_cnt), 128'(0));
    chk("reset_dst0", rsp_dst0, 128'(0));
    chk("reset_err", 128'(rsp_err), 128'(0));
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single 32-bit op
    s0[0] = {4{32'd5}};
    s1[0] = {4{32'd7}};
    s2[0] = '0;
    pr[0] = 6'b00_11_11;
    sg[0] = '0;
    req_valid = 2'b01;
    do_op(0, 0, 0, waited);
    chk("single_dst0", rsp_dst0, {4{32'd12}});

    // round robin 0,1,0,1
    do_reset();
    req_valid = '1;
    for (int n = 0; n < 4; n++) begin
      do_op(0, 1, 0, waited);
      chk("rr_order", 128'(last), 128'(n % 2));
    end

    // backpressure with requester 1 waiting
    do_reset();
    rand_req(0);
    rand_req(1);
    req_valid = '1;
    do_op(5, 0, 0, waited);
    req_valid = 2'b10;
    do_op(0, 0, 0, waited);
    chk("bp_next_latency", 128'(waited), 128'(0));
    chk("bp_next_id", 128'(last), 128'(1));

    // illegal precision
    rand_req(0);
    pr[0] = 6'b01_00_10;
    req_valid = 2'b01;
    do_op(1, 0, 0, waited);

    // reset while responding
    rand_req(1);
    req_valid = 2'b10;
    do_op(3, 0, 1, waited);
    rand_req(0);
    rand_req(1);
    req_valid = '1;
    #1;
    chk("post_rst_gnt", 128'(req_ready), 128'(1));
    do_op(0, 0, 0, waited);

    // counter wrap
    req_valid = '0;
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    cnt = 16'hFFFF;
    @(negedge clk);
    chk("wrap_pre", 128'(op_cnt), 128'(16'hFFFF));
    rand_req(0);
    req_valid = 2'b01;
    do_op(0, 0, 0, waited);
    chk("wrap_zero", 128'(op_cnt), 128'(0));

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < NREQ; i++) rand_req(i);
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_op($urandom_range(0, 3), bit'($urandom % 2), 0, waited);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
